// File: rtl/mips_cpu_hilo_muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// 32 iterations plus a sign-fix cycle; MTHI/MTLO complete in a single cycle.
module mips_cpu_hilo_muldiv #(
   parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;

   // r_acc is {product} for multiply and {remainder, dividend/quotient} for divide
   logic [63:0] r_acc;
   logic [31:0] r_opnd;
   logic [4:0]  r_cnt;
   logic        r_is_div;
   logic        r_neg_lo;
   logic        r_neg_hi;
   logic        r_div0;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_done;

   logic        w_signed;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_acc;
   logic [32:0] w_div_shift;
   logic        w_div_ge;
   logic [31:0] w_div_diff;
   logic [63:0] w_div_acc;
   logic [63:0] w_prod_fix;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;

   assign w_signed = ~op[0];
   assign w_abs_a  = (w_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
   assign w_abs_b  = (w_signed && op_b[31]) ? (32'd0 - op_b) : op_b;

   assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
   assign w_mul_acc = {w_mul_sum, r_acc[31:1]};

   // Remainder is below the divisor, so when the trial subtraction succeeds the
   // difference always fits in 32 bits.
   assign w_div_shift = r_acc[63:31];
   assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
   assign w_div_diff  = w_div_shift[31:0] - r_opnd;
   assign w_div_acc   = w_div_ge ? {w_div_diff, r_acc[30:0], 1'b1}
                                 : {w_div_shift[31:0], r_acc[30:0], 1'b0};

   assign w_prod_fix = r_neg_lo ? (64'd0 - r_acc) : r_acc;
   assign w_quo_fix  = r_neg_lo ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
   assign w_rem_fix  = r_neg_hi ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start && !op[2]) w_state_next = S_RUN;
         S_RUN:   if (r_cnt == 5'd31) w_state_next = S_FIX;
         S_FIX:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_acc    <= 64'd0;
         r_opnd   <= 32'd0;
         r_cnt    <= 5'd0;
         r_is_div <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_div0   <= 1'b0;
         r_hi     <= 32'd0;
         r_lo     <= 32'd0;
         r_done   <= 1'b0;
      end else if (clk_enable) begin
         r_state <= w_state_next;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  case (op)
                     3'b100: r_hi <= op_a;
                     3'b101: r_lo <= op_a;
                     3'b000, 3'b001, 3'b010, 3'b011: begin
                        r_is_div <= op[1];
                        r_cnt    <= 5'd0;
                        r_neg_lo <= w_signed & (op_a[31] ^ op_b[31]);
                        r_neg_hi <= w_signed & op_a[31];
                        r_div0   <= op[1] & (op_b == 32'd0);
                        // Divide walks the dividend through the low half; multiply walks the multiplier
                        if (op[1]) begin
                           r_opnd <= w_abs_b;
                           r_acc  <= {32'd0, w_abs_a};
                        end else begin
                           r_opnd <= w_abs_a;
                           r_acc  <= {32'd0, w_abs_b};
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               r_acc <= r_is_div ? w_div_acc : w_mul_acc;
               r_cnt <= r_cnt + 5'd1;
            end
            S_FIX: begin
               r_done <= 1'b1;
               if (r_is_div) begin
                  // A zero divisor leaves |dividend| as remainder, so the sign fix restores op_a
                  r_hi <= w_rem_fix;
                  r_lo <= r_div0 ? DIV0_LO : w_quo_fix;
               end else begin
                  r_hi <= w_prod_fix[63:32];
                  r_lo <= w_prod_fix[31:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
